// File: rtl/seven_segment_scan.sv
// Multiplexed common-anode hex display driver: serial nibble store, prescaled digit scan, registered seg/an.
// Optional leading-zero blanking is enabled by defining SEVSEG_BLANK_EN.
module seven_segment_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Load,
  input  logic [3:0]        Din,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]        d_q [DIGITS];
  logic [3:0]        d_d [DIGITS];
  logic [PW-1:0]     pc_q, pc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        cur_nib;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) d_d[i] = d_q[i];
    if (Load) begin
      d_d[0] = Din;
      for (int unsigned i = 1; i < DIGITS; i++) d_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    pc_d  = pc_q + 1'b1;
    idx_d = idx_q;
    if (pc_q == PW'(SCAN_DIV - 1)) begin
      pc_d  = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEVSEG_BLANK_EN
  // zero_above[i] is set when every digit from i upwards holds zero.
  logic [DIGITS:0] zero_above;
  always_comb begin
    zero_above         = '0;
    zero_above[DIGITS] = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++)
      zero_above[DIGITS-1-k] = zero_above[DIGITS-k] && (d_q[DIGITS-1-k] == 4'h0);
  end
`endif

  always_comb begin
    cur_nib = d_q[idx_q];
    an_d    = ~(DIGITS'(1) << idx_q);
`ifdef SEVSEG_BLANK_EN
    seg_d   = ((idx_q != '0) && zero_above[idx_q]) ? '1 : decode(cur_nib);
`else
    seg_d   = decode(cur_nib);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q   <= '{default: '0};
      pc_q  <= '0;
      idx_q <= '0;
      seg_q <= '1;
      an_q  <= '1;
    end else begin
      d_q   <= d_d;
      pc_q  <= pc_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan: a reference model predicts seg/an per edge, a monitor compares.
module tb_seven_segment_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              Load = 1'b0;
  logic [3:0]        Din = 4'h0;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  int errors = 0;
  int checks = 0;
  int sb_checks = 0;

  seven_segment_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .Load(Load), .Din(Din), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

`ifdef SEVSEG_BLANK_EN
  localparam logic [6:0] ZERO_HI = 7'b1111111;
`else
  localparam logic [6:0] ZERO_HI = 7'b1000000;
`endif

  // Reference model: digit store as a queue (index 0 = rightmost), scan position from edge count.
  logic [3:0]  mdl_d [$];
  int          n_edges;
  logic [10:0] exp_q [$];

  task automatic model_clear();
    mdl_d = {4'h0, 4'h0, 4'h0, 4'h0};
    n_edges = 0;
  endtask

  initial model_clear();
  always @(negedge reset) model_clear();

  always @(posedge clk) begin
    if (!reset) begin
      model_clear();
    end else begin
      int idx;
      bit blank;
      logic [6:0] es;
      logic [3:0] ea;
      idx = (n_edges / SCAN_DIV) % DIGITS;
      blank = 1'b0;
`ifdef SEVSEG_BLANK_EN
      if (idx > 0) begin
        blank = 1'b1;
        for (int j = idx; j < DIGITS; j++) if (mdl_d[j] != 4'h0) blank = 1'b0;
      end
`endif
      es = blank ? 7'h7F : DEC[mdl_d[idx]];
      ea = ~(4'b0001 << idx);
      exp_q.push_back({es, ea});
      n_edges++;
      if (Load) begin
        mdl_d.push_front(Din);
        void'(mdl_d.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      checks++;
      if (seg !== 7'h7F || an !== 4'hF) begin
        errors++;
        $display("FAIL reset_hold: got seg=%b an=%b, expected seg=1111111 an=1111", seg, an);
      end
    end else if (exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      checks++;
      sb_checks++;
      if (seg !== e[10:4] || an !== e[3:0]) begin
        errors++;
        $display("FAIL scoreboard@%0t: got seg=%b an=%b, expected seg=%b an=%b",
                 $time, seg, an, e[10:4], e[3:0]);
      end
    end
  end

  task automatic check_now(input string name, input logic [6:0] es, input logic [3:0] ea);
    checks++;
    if (seg !== es || an !== ea) begin
      errors++;
      $display("FAIL %s: got seg=%b an=%b, expected seg=%b an=%b", name, seg, an, es, ea);
    end
  endtask

  task automatic wait_show(input string name, input logic [3:0] target, input logic [6:0] es);
    bit found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an === target) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: timeout waiting for an=%b, last an=%b", name, target, an);
    end else if (seg !== es) begin
      errors++;
      $display("FAIL %s: got seg=%b at an=%b, expected seg=%b", name, seg, an, es);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    Load = 1'b0;
    #1 check_now("reset_async", 7'h7F, 4'hF);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic load_seq(input logic [3:0] vals [$]);
    foreach (vals[i]) begin
      @(negedge clk);
      Load = 1'b1;
      Din  = vals[i];
    end
    @(negedge clk);
    Load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t, expected end before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12 check_now("reset_initial", 7'h7F, 4'hF);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 check_now("first_edge", 7'b1000000, 4'b1110);

    // Idle scan: the scoreboard checks sequence and hold length.
    repeat (20) @(negedge clk);

    do_reset();
    load_seq('{4'hF, 4'hE});
    wait_show("two_nib_d0", 4'b1110, 7'b0000110);
    wait_show("two_nib_d1", 4'b1101, 7'b0001110);
    wait_show("two_nib_d2", 4'b1011, ZERO_HI);

    do_reset();
    load_seq('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
    wait_show("overflow_d3", 4'b0111, 7'b0100100);
    wait_show("overflow_d0", 4'b1110, 7'b0010010);

    // Reset asserted while the third nibble is being loaded.
    @(negedge clk); Load = 1'b1; Din = 4'h9;
    @(negedge clk); Din = 4'h8;
    @(negedge clk); Din = 4'h7;
    #2 reset = 1'b0;
    #1 check_now("reset_midload", 7'h7F, 4'hF);
    Load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    wait_show("midload_d0", 4'b1110, 7'b1000000);
    wait_show("midload_d1", 4'b1101, ZERO_HI);
    wait_show("midload_d3", 4'b0111, ZERO_HI);

    do_reset();
    load_seq('{4'h7});
    wait_show("blank_d3", 4'b0111, ZERO_HI);
    wait_show("blank_d2", 4'b1011, ZERO_HI);
    wait_show("blank_d0", 4'b1110, 7'b1111000);

    // Randomized loads with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      Load = ($urandom_range(0, 2) == 0);
      Din  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    Load = 1'b0;
    repeat (4) @(negedge clk);

    checks++;
    if (sb_checks < 1000) begin
      errors++;
      $display("FAIL scoreboard_activity: got %0d compares, expected at least 1000", sb_checks);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
